// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer: FSM states,
// ALU operation encodings and keypad codes.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Sequencer <-> ALU request/completion bundle.
interface calc_sequencer_if #(parameter int W = 10);

    // alu_start is a one-cycle request with alu_a/alu_b/alu_op stable while it
    // is high; alu_done is a one-cycle completion and alu_result/alu_err are
    // only meaningful in that cycle. There is no backpressure in either direction.
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic         alu_start;
    logic         alu_done;
    logic [W-1:0] alu_result;
    logic         alu_err;

    modport master (
        output alu_a, alu_b, alu_op, alu_start,
        input  alu_done, alu_result, alu_err
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_start,
        output alu_done, alu_result, alu_err
    );

endinterface

// File: rtl/key_conditioner.sv
// Keypad synchronizer and rising-edge event generator; the optional debounce
// filter is built when CALC_DEBOUNCE_EN is defined.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_pressed,
    input  logic [3:0] keypad_out,
    output logic       key_evt,
    output logic [3:0] key_code
);

    logic [1:0] key_sync;
    logic [3:0] code_s1;
    logic [3:0] code_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync <= '0;
            code_s1  <= '0;
            code_s2  <= '0;
        end else begin
            key_sync <= {key_sync[0], key_pressed};
            code_s1  <= keypad_out;
            code_s2  <= code_s1;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] db_cnt;
    logic          key_level;
    logic          key_level_d;
    logic [3:0]    code_hold;

    // key_level follows the synchronized strobe only after DEBOUNCE_CYCLES
    // consecutive samples that disagree with it; any agreeing sample restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt      <= '0;
            key_level   <= 1'b0;
            key_level_d <= 1'b0;
            code_hold   <= '0;
        end else begin
            key_level_d <= key_level;
            if (key_sync[1] == key_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt    <= '0;
                key_level <= key_sync[1];
                if (key_sync[1]) code_hold <= code_s2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign key_evt  = key_level & ~key_level_d;
    assign key_code = code_hold;
`else
    localparam int db_cycles_unused = DEBOUNCE_CYCLES;

    logic key_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_prev <= 1'b0;
        else        key_prev <= key_sync[1];
    end

    assign key_evt  = key_sync[1] & ~key_prev;
    assign key_code = code_s2;
`endif

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: builds operands from keypad digits and drives the
// ALU handshake. Define CALC_DEBOUNCE_EN to add key debouncing.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W               = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_pressed,
    input  logic [3:0]       keypad_out,
    calc_sequencer_if.master alu,
    output logic [W-1:0]     reg_display,
    output logic             err,
    output state_t           state_dbg
);

    localparam logic [W+3:0] TEN     = (W+4)'(10);
    localparam logic [W+3:0] ACC_MAX = {4'b0, {W{1'b1}}};

    logic       key_evt;
    logic [3:0] key_code;
    state_t     state;

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keys (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_pressed (key_pressed),
        .keypad_out  (keypad_out),
        .key_evt     (key_evt),
        .key_code    (key_code)
    );

    // A digit that would push the operand past W bits is dropped.
    function automatic logic [W-1:0] append_digit(input logic [W-1:0] acc,
                                                  input logic [3:0]   d);
        logic [W+3:0] ext;
        ext = {4'b0, acc} * TEN + {{W{1'b0}}, d};
        return (ext > ACC_MAX) ? acc : ext[W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_ENTER_A;
            alu.alu_a     <= '0;
            alu.alu_b     <= '0;
            alu.alu_op    <= OP_ADD;
            alu.alu_start <= 1'b0;
        end else begin
            alu.alu_start <= 1'b0;
            if (key_evt && key_code == KEY_CLR) begin
                state      <= ST_ENTER_A;
                alu.alu_a  <= '0;
                alu.alu_b  <= '0;
                alu.alu_op <= OP_ADD;
            end else begin
                case (state)
                    ST_ENTER_A: begin
                        if (key_evt && is_digit(key_code)) begin
                            alu.alu_a <= append_digit(alu.alu_a, key_code);
                        end else if (key_evt && is_op(key_code)) begin
                            alu.alu_op <= key_to_op(key_code);
                            alu.alu_b  <= '0;
                            state      <= ST_ENTER_B;
                        end
                    end
                    ST_ENTER_B: begin
                        if (key_evt && is_digit(key_code)) begin
                            alu.alu_b <= append_digit(alu.alu_b, key_code);
                        end else if (key_evt && is_op(key_code)) begin
                            alu.alu_op <= key_to_op(key_code);
                        end else if (key_evt && key_code == KEY_EQ) begin
                            alu.alu_start <= 1'b1;
                            state         <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (alu.alu_done) begin
                            if (alu.alu_err) begin
                                state <= ST_ERR;
                            end else begin
                                alu.alu_a <= alu.alu_result;
                                state     <= ST_SHOW;
                            end
                        end
                    end
                    ST_SHOW: begin
                        if (key_evt && is_digit(key_code)) begin
                            alu.alu_a <= W'(key_code);
                            state     <= ST_ENTER_A;
                        end else if (key_evt && is_op(key_code)) begin
                            alu.alu_op <= key_to_op(key_code);
                            alu.alu_b  <= '0;
                            state      <= ST_ENTER_B;
                        end
                    end
                    ST_ERR:  state <= ST_ERR;
                    default: state <= ST_ENTER_A;
                endcase
            end
        end
    end

    always_comb begin
        reg_display = alu.alu_a;
        case (state)
            ST_ENTER_B, ST_EXEC: reg_display = alu.alu_b;
            ST_ERR:              reg_display = {W{1'b1}};
            default:             reg_display = alu.alu_a;
        endcase
    end

    assign err       = (state == ST_ERR);
    assign state_dbg = state;

endmodule
